// File: rtl/apb_slv_pkg.sv
// Shared definitions for the four-slave APB register bank: phase encoding,
// default geometry, the ID word base and the register-index slice of paddr.
package apb_slv_pkg;

  localparam int          DEF_NUM_SLV  = 4;
  localparam int          DEF_NUM_REGS = 16;
  localparam logic [31:0] DEF_ID_BASE  = 32'hAB00_0000;

  // Register index within a bank is paddr[5:2]; every other address bit aliases.
  localparam int REG_IDX_MSB = 5;
  localparam int REG_IDX_LSB = 2;
  localparam int REG_IDX_W   = REG_IDX_MSB - REG_IDX_LSB + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } phase_e;

  // Read-only register 0 of bank s returns the ID base with the slave number OR-ed in.
  function automatic logic [31:0] f_id_word(input logic [31:0] base, input int unsigned slv);
    return base | slv;
  endfunction

endpackage

// File: rtl/apb_slv_prot_chk.sv
// APB protocol checker for apb_slave_bank. Only instantiated when
// APB_SLV_PROT_CHECK_EN is defined. Flags multi-hot selects, penable outside
// the access cycle, a dropped access cycle and bus signals that move between
// SETUP and ACCESS. Produces a per-cycle error pulse, a sticky flag and a
// saturating 8-bit error count; err_clr wins over a coincident error.
module apb_slv_prot_chk
  import apb_slv_pkg::*;
#(
  parameter int NUM_SLV = DEF_NUM_SLV
) (
  input  logic               clock,
  input  logic               hresetn,
  input  phase_e             i_phase,
  input  logic [31:0]        i_paddr,
  input  logic               i_penable,
  input  logic               i_pwrite,
  input  logic [31:0]        i_pwdata,
  input  logic [NUM_SLV-1:0] i_pselx,
  input  logic [31:0]        i_setup_paddr,
  input  logic               i_setup_pwrite,
  input  logic [31:0]        i_setup_pwdata,
  input  logic [NUM_SLV-1:0] i_setup_pselx,
  input  logic               i_err_clr,
  output logic               o_err,
  output logic               o_perr,
  output logic [7:0]         o_err_cnt
);

  logic       w_multi_hot;
  logic       w_en_early;
  logic       w_access_drop;
  logic       w_unstable;
  logic       r_perr;
  logic [7:0] r_err_cnt;

  // Classify the current cycle against the phase the bank expects.
  always_comb begin
    w_multi_hot   = (i_pselx & (i_pselx - NUM_SLV'(1))) != '0;
    w_en_early    = i_penable && (i_phase != ACCESS);
    w_access_drop = (i_phase == ACCESS) && !i_penable && (i_pselx != '0);
    w_unstable    = (i_phase == ACCESS) &&
                    ((i_paddr  != i_setup_paddr)  ||
                     (i_pwrite != i_setup_pwrite) ||
                     (i_pwdata != i_setup_pwdata) ||
                     (i_pselx  != i_setup_pselx));
    o_err         = w_multi_hot || w_en_early || w_access_drop || w_unstable;
  end

  // Sticky flag and saturating count; a clear in the same cycle discards the new error.
  always_ff @(posedge clock or negedge hresetn) begin
    if (!hresetn) begin
      r_perr    <= 1'b0;
      r_err_cnt <= '0;
    end else if (i_err_clr) begin
      r_perr    <= 1'b0;
      r_err_cnt <= '0;
    end else if (o_err) begin
      r_perr <= 1'b1;
      if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_perr    = r_perr;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/apb_slave_bank.sv
// Four-slave zero-wait-state APB register bank sitting behind the AHB-to-APB
// bridge. Each bank holds NUM_REGS 32-bit registers indexed by paddr[5:2];
// register 0 is a read-only ID word. Read data is registered at the end of
// SETUP and held through ACCESS; writes commit at the end of ACCESS.
// Optional protocol checker: define APB_SLV_PROT_CHECK_EN.
//
// state  | meaning
// IDLE   | bus quiet in the previous cycle; current cycle may start a SETUP
// SETUP  | previous cycle was a SETUP; current cycle is the expected ACCESS
// ACCESS | previous cycle was an ACCESS; a new SETUP may follow back-to-back
module apb_slave_bank
  import apb_slv_pkg::*;
#(
  parameter int          NUM_SLV  = DEF_NUM_SLV,
  parameter int          NUM_REGS = DEF_NUM_REGS,
  parameter logic [31:0] ID_BASE  = DEF_ID_BASE
) (
  input  logic               clock,
  input  logic               hresetn,
  input  logic [31:0]        paddr,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  input  logic [NUM_SLV-1:0] pselx,
  output logic [31:0]        prdata,
  input  logic               err_clr,
  output logic               perr,
  output logic [7:0]         err_cnt
);

  localparam int SLV_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  phase_e               r_state;
  phase_e               w_phase;
  logic [31:0]          r_prdata;
  logic [31:0]          r_mem [NUM_SLV][NUM_REGS];
  logic [SLV_W-1:0]     w_sel_slv;
  logic [REG_IDX_W-1:0] w_rd_idx;
  logic [31:0]          w_rd_val;
  logic [SLV_W-1:0]     r_setup_slv;
  logic [REG_IDX_W-1:0] r_setup_idx;
  logic                 r_setup_write;
  logic                 w_wr_en;
  logic                 w_err;

`ifdef APB_SLV_PROT_CHECK_EN
  logic [31:0]          r_setup_addr;
  logic [31:0]          r_setup_wdata;
  logic [NUM_SLV-1:0]   r_setup_sel;
`endif

  assign w_rd_idx = paddr[REG_IDX_MSB:REG_IDX_LSB];

  // Slave number from the select vector; the lowest set bit wins on a multi-hot select.
  always_comb begin
    w_sel_slv = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (pselx[i]) begin
        w_sel_slv = SLV_W'(i);
      end
    end
  end

  // Read mux: register 0 is the constant ID word, the rest come from storage.
  always_comb begin
    if (w_rd_idx == '0) begin
      w_rd_val = f_id_word(ID_BASE, 32'(w_sel_slv));
    end else begin
      w_rd_val = r_mem[w_sel_slv][w_rd_idx];
    end
  end

  // Phase of the current bus cycle, derived from what the previous cycle was.
  always_comb begin
    w_phase = IDLE;
    if (r_state == SETUP) begin
      w_phase = ACCESS;
    end else if ((pselx != '0) && !penable) begin
      w_phase = SETUP;
    end
  end

  assign w_wr_en = (w_phase == ACCESS) && penable && r_setup_write &&
                   !w_err && (r_setup_idx != '0);

  // Phase FSM with registered read data and the SETUP-phase capture registers.
  always_ff @(posedge clock or negedge hresetn) begin
    if (!hresetn) begin
      r_state       <= IDLE;
      r_prdata      <= '0;
      r_setup_slv   <= '0;
      r_setup_idx   <= '0;
      r_setup_write <= 1'b0;
`ifdef APB_SLV_PROT_CHECK_EN
      r_setup_addr  <= '0;
      r_setup_wdata <= '0;
      r_setup_sel   <= '0;
`endif
    end else if (w_err) begin
      r_state  <= IDLE;
      r_prdata <= '0;
    end else begin
      r_state <= w_phase;
      case (w_phase)
        SETUP: begin
          r_prdata      <= pwrite ? 32'd0 : w_rd_val;
          r_setup_slv   <= w_sel_slv;
          r_setup_idx   <= w_rd_idx;
          r_setup_write <= pwrite;
`ifdef APB_SLV_PROT_CHECK_EN
          r_setup_addr  <= paddr;
          r_setup_wdata <= pwdata;
          r_setup_sel   <= pselx;
`endif
        end
        default: begin
          r_prdata <= '0;
        end
      endcase
    end
  end

  // Register storage; writes land at the edge that ends a valid ACCESS cycle.
  always_ff @(posedge clock or negedge hresetn) begin
    if (!hresetn) begin
      for (int s = 0; s < NUM_SLV; s++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          r_mem[s][r] <= '0;
        end
      end
    end else if (w_wr_en) begin
      r_mem[r_setup_slv][r_setup_idx] <= pwdata;
    end
  end

  assign prdata = r_prdata;

`ifdef APB_SLV_PROT_CHECK_EN
  apb_slv_prot_chk #(
    .NUM_SLV (NUM_SLV)
  ) u_prot_chk (
    .clock          (clock),
    .hresetn        (hresetn),
    .i_phase        (w_phase),
    .i_paddr        (paddr),
    .i_penable      (penable),
    .i_pwrite       (pwrite),
    .i_pwdata       (pwdata),
    .i_pselx        (pselx),
    .i_setup_paddr  (r_setup_addr),
    .i_setup_pwrite (r_setup_write),
    .i_setup_pwdata (r_setup_wdata),
    .i_setup_pselx  (r_setup_sel),
    .i_err_clr      (err_clr),
    .o_err          (w_err),
    .o_perr         (perr),
    .o_err_cnt      (err_cnt)
  );
`else
  assign w_err   = 1'b0;
  assign perr    = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_apb_slave_bank.sv
// Self-checking bench for apb_slave_bank. Expected read data comes from a
// small reference register model and is queued when the read is issued.
// The protocol-checker scenarios run when APB_SLV_PROT_CHECK_EN is defined;
// otherwise the unchecked behaviour (lowest-index select, tied-off flags) is checked.
module tb_apb_slave_bank;

  logic        clock = 1'b0;
  logic        hresetn;
  logic [31:0] paddr;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pselx;
  logic [31:0] prdata;
  logic        err_clr;
  logic        perr;
  logic [7:0]  err_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [4][16];

  always #5 clock = ~clock;

  apb_slave_bank dut (
    .clock   (clock),
    .hresetn (hresetn),
    .paddr   (paddr),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pselx   (pselx),
    .prdata  (prdata),
    .err_clr (err_clr),
    .perr    (perr),
    .err_cnt (err_cnt)
  );

  function automatic int sel_index(input logic [3:0] sel);
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input int s, input logic [31:0] addr);
    logic [3:0] idx;
    idx = addr[5:2];
    if (idx == 4'd0) return 32'hAB00_0000 | s;
    return ref_mem[s][idx];
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 16; r++)
        ref_mem[s][r] = 32'd0;
  endtask

  task automatic bus_idle(input int n);
    pselx = 4'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // One SETUP + ACCESS transfer starting just after a rising edge; rd is prdata
  // sampled mid-ACCESS. Returns just after the edge that ends ACCESS.
  task automatic xfer(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data, output logic [31:0] rd);
    int s;
    s = sel_index(sel);
    pselx = sel; paddr = addr; pwrite = wr; pwdata = data; penable = 1'b0;
    if (!wr) exp_q.push_back(model_read(s, addr));
    @(posedge clock); #1;
    penable = 1'b1;
    if (wr && addr[5:2] != 4'd0) ref_mem[s][addr[5:2]] = data;
    @(negedge clock);
    rd = prdata;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; err_clr = 1'b0;
    bus_idle(0);
    model_clear();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (prdata !== 32'd0) begin errors++; $display("FAIL reset_prdata: got %h expected %h", prdata, 32'd0); end
    checks++;
    if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", perr); end
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %h expected 00", err_cnt); end
    hresetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_id_read();
    logic [31:0] rd, exp;
    xfer(4'b0100, 32'h0000_0000, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp || rd !== 32'hAB00_0002) begin errors++; $display("FAIL id_read_s2: got %h expected %h", rd, exp); end
    bus_idle(1);
    @(negedge clock);
    checks++;
    if (prdata !== 32'd0) begin errors++; $display("FAIL prdata_after_access: got %h expected 0", prdata); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp;
    xfer(4'b0010, 32'h0000_000C, 1'b1, 32'hDEAD_BEEF, rd);
    xfer(4'b0010, 32'h0000_000C, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL b2b_read_s1r3: got %h expected %h", rd, exp); end
    xfer(4'b0001, 32'h0000_000C, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL other_slave_s0r3: got %h expected %h", rd, exp); end
    bus_idle(1);
  endtask

  task automatic test_ro_reg0();
    logic [31:0] rd, exp;
    xfer(4'b1000, 32'h0000_0000, 1'b1, 32'h1234_5678, rd);
    xfer(4'b1000, 32'h0000_0000, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL ro_reg0_s3: got %h expected %h", rd, exp); end
    bus_idle(1);
  endtask

  task automatic test_alias();
    logic [31:0] rd, exp;
    xfer(4'b0001, 32'h0000_0104, 1'b1, 32'h0000_0055, rd);
    xfer(4'b0001, 32'h0000_0004, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL alias_0x04: got %h expected %h", rd, exp); end
    xfer(4'b0001, 32'hFFFF_FF07, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL alias_hi_lo_bits: got %h expected %h", rd, exp); end
    bus_idle(1);
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, addr;
    logic [3:0]  sel;
    for (int i = 0; i < 24; i++) begin
      sel  = 4'b0001 << $urandom_range(0, 3);
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0) begin
        xfer(sel, addr, 1'b1, $urandom, rd);
      end else begin
        xfer(sel, addr, 1'b0, 32'd0, rd);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL random_read_%0d: got %h expected %h", i, rd, exp); end
      end
      if ($urandom_range(0, 2) == 0) bus_idle(1);
    end
    bus_idle(1);
  endtask

`ifdef APB_SLV_PROT_CHECK_EN
  task automatic test_prot_check();
    logic [31:0] rd, exp;
    // Multi-hot select in SETUP; the bus then goes idle.
    pselx = 4'b0011; paddr = 32'h0000_0008; pwrite = 1'b1; pwdata = 32'h0000_CAFE; penable = 1'b0;
    @(posedge clock); #1;
    bus_idle(0);
    @(negedge clock);
    checks++;
    if (perr !== 1'b1) begin errors++; $display("FAIL multihot_perr: got %b expected 1", perr); end
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL multihot_cnt: got %h expected 01", err_cnt); end
    @(posedge clock); #1;
    xfer(4'b0001, 32'h0000_0008, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL multihot_no_write_s0: got %h expected %h", rd, exp); end
    xfer(4'b0010, 32'h0000_0008, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL multihot_no_write_s1: got %h expected %h", rd, exp); end
    bus_idle(1);
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL clean_reads_cnt: got %h expected 01", err_cnt); end
    // penable asserted while idle: one error per cycle, saturating.
    penable = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    checks++;
    if (err_cnt !== 8'd11) begin errors++; $display("FAIL idle_penable_cnt11: got %h expected 0b", err_cnt); end
    repeat (290) @(posedge clock);
    #1;
    bus_idle(0);
    @(negedge clock);
    checks++;
    if (err_cnt !== 8'hFF) begin errors++; $display("FAIL saturate_cnt: got %h expected ff", err_cnt); end
    // Clear coincident with a new error: the error is lost.
    @(posedge clock); #1;
    penable = 1'b1; err_clr = 1'b1;
    @(posedge clock); #1;
    penable = 1'b0; err_clr = 1'b0;
    @(negedge clock);
    checks++;
    if (perr !== 1'b0) begin errors++; $display("FAIL clr_perr: got %b expected 0", perr); end
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt: got %h expected 00", err_cnt); end
    // Address moves between SETUP and ACCESS: write dropped.
    @(posedge clock); #1;
    pselx = 4'b0001; paddr = 32'h0000_0024; pwrite = 1'b1; pwdata = 32'h0000_0099; penable = 1'b0;
    @(posedge clock); #1;
    penable = 1'b1; paddr = 32'h0000_0028;
    @(posedge clock); #1;
    bus_idle(0);
    @(negedge clock);
    checks++;
    if (err_cnt !== 8'd1 || perr !== 1'b1) begin errors++; $display("FAIL unstable_err: got cnt %h perr %b expected 01 1", err_cnt, perr); end
    @(posedge clock); #1;
    xfer(4'b0001, 32'h0000_0024, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL unstable_no_write: got %h expected %h", rd, exp); end
    xfer(4'b0001, 32'h0000_0028, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL unstable_no_write_alt: got %h expected %h", rd, exp); end
    bus_idle(0);
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    bus_idle(1);
  endtask
`else
  task automatic test_no_check();
    logic [31:0] rd, exp;
    xfer(4'b0011, 32'h0000_0008, 1'b1, 32'h0000_0077, rd);
    xfer(4'b0001, 32'h0000_0008, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp || rd !== 32'h0000_0077) begin errors++; $display("FAIL multihot_lowest_s0: got %h expected %h", rd, exp); end
    xfer(4'b0010, 32'h0000_0008, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL multihot_s1_untouched: got %h expected %h", rd, exp); end
    bus_idle(0);
    penable = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    err_clr = 1'b1;
    @(negedge clock);
    checks++;
    if (perr !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL nochk_flags: got perr %b cnt %h expected 0 00", perr, err_cnt); end
    checks++;
    if (prdata !== 32'd0) begin errors++; $display("FAIL nochk_prdata_idle: got %h expected 0", prdata); end
    @(posedge clock); #1;
    err_clr = 1'b0;
    bus_idle(1);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] rd, exp;
    xfer(4'b0001, 32'h0000_0014, 1'b1, 32'h0000_0011, rd);
    pselx = 4'b0001; paddr = 32'h0000_001C; pwrite = 1'b1; pwdata = 32'h0000_00A5; penable = 1'b0;
    @(posedge clock); #1;
    penable = 1'b1;
    @(negedge clock);
    hresetn = 1'b0;
    #1;
    bus_idle(0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    hresetn = 1'b1;
    model_clear();
    checks++;
    if (prdata !== 32'd0 || perr !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL midreset_outputs: got %h %b %h expected 0 0 00", prdata, perr, err_cnt);
    end
    @(posedge clock); #1;
    xfer(4'b0001, 32'h0000_001C, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp || rd !== 32'd0) begin errors++; $display("FAIL midreset_s0r7: got %h expected %h", rd, exp); end
    xfer(4'b0001, 32'h0000_0014, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL midreset_s0r5: got %h expected %h", rd, exp); end
    xfer(4'b0010, 32'h0000_000C, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL midreset_s1r3: got %h expected %h", rd, exp); end
    xfer(4'b1000, 32'h0000_0000, 1'b0, 32'd0, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL midreset_id_s3: got %h expected %h", rd, exp); end
    bus_idle(1);
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_back_to_back();
    test_ro_reg0();
    test_alias();
    test_random();
`ifdef APB_SLV_PROT_CHECK_EN
    test_prot_check();
`else
    test_no_check();
`endif
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
